// File: rtl/sixty_four_bit_csa_timed_if.sv
// sixty_four_bit_csa_timed_if: addend/sum/checker bundle for the timed 64-bit carry-select adder
`timescale 1ns/1ps
interface sixty_four_bit_csa_timed_if #(
  parameter int ERR_CNT_W = 16
);
  logic [63:0] A;
  logic [63:0] B;
  logic C0;
  logic [63:0] S;
  logic C_Out;
  logic err;
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (output A, B, C0, input S, C_Out, err, err_cnt);
  modport slave (input A, B, C0, output S, C_Out, err, err_cnt);
endinterface

// File: rtl/sixty_four_bit_csa_timed.sv
// sixty_four_bit_csa_timed: gate-level 64-bit carry-select adder with reference checker; CSA_GATE_DELAY_EN gives every gate 1 ns delay
`timescale 1ns/1ps
`ifdef CSA_GATE_DELAY_EN
`define CSA_GD #1
`else
`define CSA_GD
`endif
module sixty_four_bit_csa_timed #(
  parameter int BLK_W = 4,
  parameter int ERR_CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  sixty_four_bit_csa_timed_if.slave bus
);
  localparam int NB = 64 / BLK_W;
  // cs/ncs carry both polarities of each block carry so every mux stage costs two gate levels
  logic [NB-1:0] cs;
  logic [NB-2:0] ncs;
  logic [63:0] sum;
  logic [64:0] ref_sum;
  logic mis;
  logic err_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  for (genvar j = 0; j < NB; j++) begin : g_blk
    for (genvar p = 0; p < (j == 0 ? 1 : 2); p++) begin : g_rca
      logic [BLK_W:0] c;
      logic [BLK_W-1:0] x;
      logic [BLK_W-1:0] s;
      logic [BLK_W-1:0] g;
      logic [BLK_W-1:0] t;
      if (j == 0) begin : g_cin
        assign c[0] = bus.C0;
      end else begin : g_cin
        assign c[0] = 1'(p);
      end
      for (genvar i = 0; i < BLK_W; i++) begin : g_fa
        localparam int K = j * BLK_W + i;
        assign `CSA_GD x[i] = bus.A[K] ^ bus.B[K];
        assign `CSA_GD s[i] = x[i] ^ c[i];
        assign `CSA_GD g[i] = bus.A[K] & bus.B[K];
        assign `CSA_GD t[i] = c[i] & x[i];
        assign `CSA_GD c[i+1] = g[i] | t[i];
      end
    end
    if (j == 0) begin : g_sel
      assign sum[BLK_W-1:0] = g_rca[0].s;
      assign cs[0] = g_rca[0].c[BLK_W];
      if (NB > 1) begin : g_n
        assign `CSA_GD ncs[0] = ~g_rca[0].c[BLK_W];
      end
    end else begin : g_sel
      logic [BLK_W-1:0] m1;
      logic [BLK_W-1:0] m0;
      logic k1;
      logic k0;
      for (genvar i = 0; i < BLK_W; i++) begin : g_mux
        assign `CSA_GD m1[i] = cs[j-1] & g_rca[1].s[i];
        assign `CSA_GD m0[i] = ncs[j-1] & g_rca[0].s[i];
        assign `CSA_GD sum[j*BLK_W+i] = m1[i] | m0[i];
      end
      assign `CSA_GD k1 = cs[j-1] & g_rca[1].c[BLK_W];
      assign `CSA_GD k0 = ncs[j-1] & g_rca[0].c[BLK_W];
      assign `CSA_GD cs[j] = k1 | k0;
      if (j < NB - 1) begin : g_n
        logic nc1;
        logic nc0;
        logic n1;
        logic n0;
        assign `CSA_GD nc1 = ~g_rca[1].c[BLK_W];
        assign `CSA_GD nc0 = ~g_rca[0].c[BLK_W];
        assign `CSA_GD n1 = cs[j-1] & nc1;
        assign `CSA_GD n0 = ncs[j-1] & nc0;
        assign `CSA_GD ncs[j] = n1 | n0;
      end
    end
  end
  assign bus.S = sum;
  assign bus.C_Out = cs[NB-1];
  assign ref_sum = 65'(bus.A) + 65'(bus.B) + 65'(bus.C0);
  assign mis = {bus.C_Out, bus.S} != ref_sum;
  // Record the mismatch seen at each edge; the count saturates at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= mis;
      if (mis && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  assign bus.err = err_q;
  assign bus.err_cnt = cnt_q;
endmodule
`undef CSA_GD

// File: tb/tb_sixty_four_bit_csa_timed.sv
// tb_sixty_four_bit_csa_timed: scoreboard bench for the timed carry-select adder and its checker
`timescale 1ns/1ps
module tb_sixty_four_bit_csa_timed;
  localparam int CW = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [64:0] exp_q[$];
  sixty_four_bit_csa_timed_if #(.ERR_CNT_W(CW)) bus ();
  sixty_four_bit_csa_timed #(.BLK_W(4), .ERR_CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic c0, input logic [64:0] want, input string nm);
    logic [64:0] e;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.C0 = c0;
    exp_q.push_back(want);
    repeat (5) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.C_Out, bus.S} !== e) begin
      n_bad++;
      $display("FAIL %s sum: got %h want %h", nm, {bus.C_Out, bus.S}, e);
    end
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s err: got %b want 0", nm, bus.err);
    end
  endtask

  task automatic test_reset;
    bus.A = '0;
    bus.B = '0;
    bus.C0 = 1'b0;
    rst_n = 1'b0;
    #20;
    n_cmp += 4;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", bus.err); end
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL reset err_cnt: got %0d want 0", bus.err_cnt); end
    if (bus.S !== 64'h0) begin n_bad++; $display("FAIL reset S: got %h want 0", bus.S); end
    if (bus.C_Out !== 1'b0) begin n_bad++; $display("FAIL reset C_Out: got %b want 0", bus.C_Out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.err !== 1'b0) begin n_bad++; $display("FAIL idle err cycle %0d: got %b want 0", i, bus.err); end
    end
    n_cmp++;
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL idle err_cnt: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_directed;
    apply(64'h1, ONES, 1'b0, {1'b1, 64'h0}, "ripple_c0");
    apply(64'h1, ONES, 1'b1, {1'b1, 64'h1}, "ripple_c1");
    apply(ONES, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, {1'b1, 64'hAAAA_AAAA_AAAA_AAA9}, "alt_c0");
    apply(ONES, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, {1'b1, 64'hAAAA_AAAA_AAAA_AAAA}, "alt_c1");
    apply(64'hFF, 64'hFF01, 1'b0, {1'b0, 64'h10000}, "cross_c0");
    apply(64'hFF, 64'hFF01, 1'b1, {1'b0, 64'h10001}, "cross_c1");
    apply(ONES, ONES, 1'b1, {1'b1, ONES}, "all_ones");
  endtask

  task automatic test_random;
    logic [63:0] a;
    logic [63:0] b;
    logic c0;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c0 = 1'($urandom_range(1));
      apply(a, b, c0, {1'b0, a} + {1'b0, b} + 65'(c0), "random");
    end
    n_cmp++;
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL random err_cnt: got %0d want 0", bus.err_cnt); end
  endtask

`ifdef CSA_GATE_DELAY_EN
  task automatic test_timing_window;
    logic [64:0] e;
    apply(64'h0, ONES, 1'b0, {1'b0, ONES}, "window_pre");
    @(posedge clk);
    #5;
    bus.C0 = 1'b1;
    exp_q.push_back({1'b1, 64'h0});
    @(posedge clk);
    #1;
    n_cmp += 2;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL window err: got %b want 1", bus.err); end
    if (bus.err_cnt !== CW'(1)) begin n_bad++; $display("FAIL window err_cnt: got %0d want 1", bus.err_cnt); end
    repeat (4) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_cmp += 2;
    if ({bus.C_Out, bus.S} !== e) begin n_bad++; $display("FAIL window settled sum: got %h want %h", {bus.C_Out, bus.S}, e); end
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL window settled err: got %b want 0", bus.err); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL window reset err_cnt: got %0d want 0", bus.err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  task automatic test_checker;
    apply(64'h1, 64'h1, 1'b0, {1'b0, 64'h2}, "force_pre");
    @(negedge clk);
    force bus.S = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 2;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL count err: got %b want 1", bus.err); end
    if (bus.err_cnt !== CW'(3)) begin n_bad++; $display("FAIL count err_cnt: got %0d want 3", bus.err_cnt); end
    repeat (17) @(posedge clk);
    #1;
    n_cmp += 2;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL saturate err: got %b want 1", bus.err); end
    if (bus.err_cnt !== CW'(15)) begin n_bad++; $display("FAIL saturate err_cnt: got %0d want 15", bus.err_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL async reset err: got %b want 0", bus.err); end
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL async reset err_cnt: got %0d want 0", bus.err_cnt); end
    @(posedge clk);
    #1;
    n_cmp += 2;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL held reset err: got %b want 0", bus.err); end
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL held reset err_cnt: got %0d want 0", bus.err_cnt); end
    @(negedge clk);
    release bus.S;
    rst_n = 1'b1;
    apply(64'h1, 64'h1, 1'b0, {1'b0, 64'h2}, "force_post");
    n_cmp++;
    if (bus.err_cnt !== '0) begin n_bad++; $display("FAIL post release err_cnt: got %0d want 0", bus.err_cnt); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
`ifdef CSA_GATE_DELAY_EN
    test_timing_window;
`endif
    test_checker;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
